// File: rtl/dds_fcw_sweep_if.sv
// Control and status bundle between a sweep controller and the DDS FCW generator.
// Master drives the sweep configuration; slave returns the FCW and status.
interface dds_fcw_sweep_if #(
  parameter int ACC_BITS   = 32,
  parameter int DWELL_BITS = 16
);
  logic                  start;
  logic                  abort;
  logic [1:0]            mode;
  logic [ACC_BITS-1:0]   fcw_start;
  logic [ACC_BITS-1:0]   fcw_stop;
  logic [ACC_BITS-1:0]   fcw_step;
  logic [DWELL_BITS-1:0] dwell;
  logic [ACC_BITS-1:0]   FCW;
  logic                  fcw_update;
  logic                  busy;
  logic                  done;
  logic                  sweep_dir;

  modport master (
    output start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    input  FCW, fcw_update, busy, done, sweep_dir
  );

  modport slave (
    input  start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    output FCW, fcw_update, busy, done, sweep_dir
  );
endinterface

// File: rtl/dds_fcw_sweep.sv
// Linear FCW sweep generator (single chirp / sawtooth / triangle) feeding the DDS
// phase accumulator; each FCW value is held dwell+1 cycles plus a one-cycle step decision.
module dds_fcw_sweep #(
  parameter int ACC_BITS   = 32,
  parameter int DWELL_BITS = 16
) (
  input  logic CLK,
  input  logic RST,
  dds_fcw_sweep_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STEP} state_t;

  state_t                state_q, state_d;
  logic [ACC_BITS-1:0]   fcw_q, fcw_d;
  logic                  upd_q, upd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dir_q, dir_d;
  logic [DWELL_BITS-1:0] cnt_q, cnt_d;

  logic [1:0]            mode_q, mode_d;
  logic [ACC_BITS-1:0]   start_q, start_d;
  logic [ACC_BITS-1:0]   stop_q, stop_d;
  logic [ACC_BITS-1:0]   step_q, step_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;

  logic is_saw, is_tri, degen;

  // Guard-bit add, saturating at the stop value.
  function automatic logic [ACC_BITS-1:0] step_up(
    input logic [ACC_BITS-1:0] cur,
    input logic [ACC_BITS-1:0] inc,
    input logic [ACC_BITS-1:0] lim
  );
    logic [ACC_BITS:0] nxt;
    nxt = {1'b0, cur} + {1'b0, inc};
    if (nxt >= {1'b0, lim}) return lim;
    return nxt[ACC_BITS-1:0];
  endfunction

  // Guard-bit subtract, saturating at the start value.
  function automatic logic [ACC_BITS-1:0] step_down(
    input logic [ACC_BITS-1:0] cur,
    input logic [ACC_BITS-1:0] dec,
    input logic [ACC_BITS-1:0] lim
  );
    logic [ACC_BITS:0] nxt;
    nxt = {1'b0, cur} - {1'b0, dec};
    if (nxt[ACC_BITS] || (nxt[ACC_BITS-1:0] <= lim)) return lim;
    return nxt[ACC_BITS-1:0];
  endfunction

  assign is_saw = (mode_q == 2'b01);
  assign is_tri = (mode_q == 2'b10);
  // Empty or inverted range, or zero step: the sweep never leaves fcw_start.
  assign degen  = (stop_q <= start_q) || (step_q == '0);

  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    upd_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          mode_d  = bus.mode;
          start_d = bus.fcw_start;
          stop_d  = bus.fcw_stop;
          step_d  = bus.fcw_step;
          dwell_d = bus.dwell;
          fcw_d   = bus.fcw_start;
          upd_d   = 1'b1;
          busy_d  = 1'b1;
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == dwell_q) state_d = S_STEP;
        else                  cnt_d   = cnt_q + DWELL_BITS'(1);
      end
      S_STEP: begin
        cnt_d   = '0;
        state_d = S_HOLD;
        if (degen) begin
          if (!is_saw && !is_tri) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (!dir_q) begin
          if (fcw_q == stop_q) begin
            if (is_saw) begin
              fcw_d = start_q;
            end else if (is_tri) begin
              dir_d = 1'b1;
              fcw_d = step_down(fcw_q, step_q, start_q);
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            fcw_d = step_up(fcw_q, step_q, stop_q);
          end
        end else begin
          if (fcw_q == start_q) begin
            dir_d = 1'b0;
            fcw_d = step_up(fcw_q, step_q, stop_q);
          end else begin
            fcw_d = step_down(fcw_q, step_q, start_q);
          end
        end
        upd_d = (fcw_d != fcw_q);
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      fcw_d   = fcw_q;
      upd_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dir_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      fcw_q   <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched sweep configuration: only meaningful once a sweep has started.
  always_ff @(posedge CLK) begin
    mode_q  <= mode_d;
    start_q <= start_d;
    stop_q  <= stop_d;
    step_q  <= step_d;
    dwell_q <= dwell_d;
  end

  assign bus.FCW        = fcw_q;
  assign bus.fcw_update = upd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sweep_dir  = dir_q;

endmodule
